// File: rtl/alu_pkg.sv
// Shared encodings for the ALU / multiply-divide slice: op codes, shift ops,
// MDU op codes and the MDU state type.
package alu_pkg;

   localparam logic [2:0] ALU_AND = 3'd0;
   localparam logic [2:0] ALU_OR  = 3'd1;
   localparam logic [2:0] ALU_XOR = 3'd2;
   localparam logic [2:0] ALU_NOR = 3'd3;
   localparam logic [2:0] ALU_ADD = 3'd4;
   localparam logic [2:0] ALU_LO  = 3'd5;
   localparam logic [2:0] ALU_SHF = 3'd6;
   localparam logic [2:0] ALU_SLT = 3'd7;

   // bit 1: arithmetic, bit 0: right
   localparam logic [1:0] SH_SLL = 2'b00;
   localparam logic [1:0] SH_SRL = 2'b01;
   localparam logic [1:0] SH_SLA = 2'b10;
   localparam logic [1:0] SH_SRA = 2'b11;

   localparam logic [1:0] MD_MULT  = 2'd0;
   localparam logic [1:0] MD_MULTU = 2'd1;
   localparam logic [1:0] MD_DIV   = 2'd2;
   localparam logic [1:0] MD_DIVU  = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } md_state_t;

   function automatic logic md_is_mult(input logic [1:0] op);
      return (op == MD_MULT) || (op == MD_MULTU);
   endfunction

   function automatic logic md_is_signed(input logic [1:0] op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

endpackage

// File: rtl/alu_mdu_mdu_iter.sv
// Iterative radix-2 multiply/divide unit owning HI/LO and the start/done handshake.
// Optional MDU_EARLY_OUT_EN: multiplies leave RUN once the remaining multiplier is zero.
module mdu_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             md_start,
   input  logic [1:0]       md_op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             md_done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH + 1);

   md_state_t          state_reg, state_next;
   logic [CW-1:0]      cnt_reg;
   logic [1:0]         op_reg;
   logic               neg_lo_reg, neg_hi_reg, dz_reg, done_reg;
   logic [WIDTH-1:0]   a_reg, mplier_reg, hi_reg, lo_reg;
   logic [2*WIDTH-1:0] acc_reg, mcand_reg;

   logic               a_neg, b_neg, run_last, early_exit;
   logic [WIDTH-1:0]   a_mag, b_mag, quo_fix, rem_fix;
   logic [2*WIDTH-1:0] mul_acc_step, div_acc_step, prod_fix;
   logic [WIDTH:0]     div_shift, div_trial;

   assign a_neg = md_is_signed(md_op) & a[WIDTH-1];
   assign b_neg = md_is_signed(md_op) & b[WIDTH-1];
   assign a_mag = a_neg ? -a : a;
   assign b_mag = b_neg ? -b : b;

   // Multiply: acc accumulates a left-shifting multiplicand, so an early exit is exact.
   assign mul_acc_step = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

   // Divide: acc = {remainder, dividend/quotient}; restoring trial subtract.
   assign div_shift    = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
   assign div_trial    = div_shift - {1'b0, mcand_reg[WIDTH-1:0]};
   assign div_acc_step = div_trial[WIDTH]
                       ? {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0}
                       : {div_trial[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};

   assign prod_fix = neg_lo_reg ? -acc_reg : acc_reg;
   assign quo_fix  = neg_lo_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
   assign rem_fix  = neg_hi_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];

   assign run_last = (cnt_reg == CW'(WIDTH));

`ifdef MDU_EARLY_OUT_EN
   assign early_exit = md_is_mult(op_reg) && (cnt_reg != '0) && (mplier_reg == '0);
`else
   assign early_exit = 1'b0;
`endif

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (md_start) state_next = RUN;
         RUN:     if (run_last || early_exit) state_next = FIX;
         FIX:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         op_reg     <= MD_MULT;
         neg_lo_reg <= 1'b0;
         neg_hi_reg <= 1'b0;
         dz_reg     <= 1'b0;
         done_reg   <= 1'b0;
         a_reg      <= '0;
         mplier_reg <= '0;
         acc_reg    <= '0;
         mcand_reg  <= '0;
         hi_reg     <= '0;
         lo_reg     <= '0;
      end else begin
         state_reg <= state_next;
         done_reg  <= (state_reg == FIX);
         case (state_reg)
            IDLE: begin
               if (md_start) begin
                  op_reg     <= md_op;
                  a_reg      <= a;
                  cnt_reg    <= '0;
                  dz_reg     <= (b == '0);
                  neg_lo_reg <= a_neg ^ b_neg;
                  if (md_is_mult(md_op)) begin
                     neg_hi_reg <= a_neg ^ b_neg;
                     acc_reg    <= '0;
                     mcand_reg  <= {{WIDTH{1'b0}}, a_mag};
                     mplier_reg <= b_mag;
                  end else begin
                     // remainder follows the dividend's sign
                     neg_hi_reg <= a_neg;
                     acc_reg    <= {{WIDTH{1'b0}}, a_mag};
                     mcand_reg  <= {{WIDTH{1'b0}}, b_mag};
                     mplier_reg <= '0;
                  end
               end
            end
            RUN: begin
               if (!(run_last || early_exit)) begin
                  cnt_reg <= cnt_reg + CW'(1);
                  if (md_is_mult(op_reg)) begin
                     acc_reg    <= mul_acc_step;
                     mcand_reg  <= mcand_reg << 1;
                     mplier_reg <= mplier_reg >> 1;
                  end else begin
                     acc_reg <= div_acc_step;
                  end
               end
            end
            FIX: begin
               if (md_is_mult(op_reg)) begin
                  {hi_reg, lo_reg} <= prod_fix;
               end else if (dz_reg) begin
                  lo_reg <= '1;
                  hi_reg <= a_reg;
               end else begin
                  lo_reg <= quo_fix;
                  hi_reg <= rem_fix;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy    = (state_reg != IDLE);
   assign md_done = done_reg;
   assign hi      = hi_reg;
   assign lo      = lo_reg;

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU: combinational logic/arith/shift/SLT datapath plus an iterative MDU.
// Build option MDU_EARLY_OUT_EN (in mdu_iter) shortens multiplies with small multipliers.
module alu_mdu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [6:0]       ctrl,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [SHW-1:0]   SH,
   input  logic             md_start,
   input  logic [1:0]       md_op,
   output logic [WIDTH-1:0] Y,
   output logic             Z,
   output logic             busy,
   output logic             md_done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   logic             cin;
   logic [WIDTH-1:0] bb, sum, and_v, or_v, xor_v, nor_v, shf, y_mux;
   logic [SHW-1:0]   shamt;

   assign cin = ctrl[3];
   assign bb  = cin ? ~B : B;
   assign sum = A + bb + {{(WIDTH-1){1'b0}}, cin};

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         assign and_v[gi] = A[gi] & bb[gi];
         assign or_v[gi]  = A[gi] | bb[gi];
         assign xor_v[gi] = A[gi] ^ bb[gi];
         assign nor_v[gi] = ~(A[gi] | bb[gi]);
      end
   endgenerate

   assign shamt = ctrl[6] ? A[SHW-1:0] : SH;

   always_comb begin
      shf = B << shamt;
      case (ctrl[5:4])
         SH_SLL, SH_SLA: shf = B << shamt;
         SH_SRL:         shf = B >> shamt;
         SH_SRA:         shf = $unsigned($signed(B) >>> shamt);
         default:        shf = B << shamt;
      endcase
   end

   // Op 5 reads the architectural LO, untouched until an operation's FIX write.
   always_comb begin
      y_mux = '0;
      case (ctrl[2:0])
         ALU_AND: y_mux = and_v;
         ALU_OR:  y_mux = or_v;
         ALU_XOR: y_mux = xor_v;
         ALU_NOR: y_mux = nor_v;
         ALU_ADD: y_mux = sum;
         ALU_LO:  y_mux = lo;
         ALU_SHF: y_mux = shf;
         ALU_SLT: y_mux = {{(WIDTH-1){1'b0}}, sum[WIDTH-1]};
         default: y_mux = '0;
      endcase
   end

   assign Y = y_mux;
   assign Z = (y_mux == '0);

   mdu_iter #(
      .WIDTH(WIDTH)
   ) u_mdu (
      .clk     (clk),
      .reset_n (reset_n),
      .md_start(md_start),
      .md_op   (md_op),
      .a       (A),
      .b       (B),
      .busy    (busy),
      .md_done (md_done),
      .hi      (hi),
      .lo      (lo)
   );

endmodule
